// File: rtl/box_place_ctrl_if.sv
// Signal bundle between the snake/collision side and the food-box placement sequencer.
// The master side owns requests, random sources and the body memory read data.
interface box_place_ctrl_if #(
  parameter int unsigned X_W   = 7,
  parameter int unsigned Y_W   = 5,
  parameter int unsigned LEN_W = 6
);
  logic             game_start;
  logic             eat;
  logic [X_W-1:0]   rand_num_x;
  logic [Y_W-1:0]   rand_num_y;
  logic [LEN_W-1:0] snake_len;
  logic [LEN_W-1:0] seg_addr;
  logic [X_W-1:0]   seg_x;
  logic [Y_W-1:0]   seg_y;
  logic [X_W-1:0]   box_x;
  logic [Y_W-1:0]   box_y;
  logic             box_load;
  logic             busy;
  logic             board_full;

  modport master (
    output game_start, eat, rand_num_x, rand_num_y, snake_len, seg_x, seg_y,
    input  seg_addr, box_x, box_y, box_load, busy, board_full
  );

  modport slave (
    input  game_start, eat, rand_num_x, rand_num_y, snake_len, seg_x, seg_y,
    output seg_addr, box_x, box_y, box_load, busy, board_full
  );
endinterface

// File: rtl/box_place_ctrl.sv
// Food-box placement sequencer: samples random cells, rejects out-of-range or occupied ones by
// scanning the snake body memory, falls back to a deterministic walk, then loads box_create.
module box_place_ctrl #(
  parameter int unsigned X_W       = 7,
  parameter int unsigned Y_W       = 5,
  parameter int unsigned X_LIMIT   = 64,
  parameter int unsigned Y_LIMIT   = 32,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned MAX_RETRY = 8
) (
  input logic             clk,
  input logic             rst_n,
  box_place_ctrl_if.slave bus
);

  localparam int unsigned CELLS   = X_LIMIT * Y_LIMIT;
  localparam int unsigned WALK_W  = $clog2(CELLS + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;

  localparam logic [X_W:0]         X_LIM       = (X_W+1)'(X_LIMIT);
  localparam logic [Y_W:0]         Y_LIM       = (Y_W+1)'(Y_LIMIT);
  localparam logic [X_W-1:0]       X_LAST      = X_W'(X_LIMIT - 1);
  localparam logic [Y_W-1:0]       Y_LAST      = Y_W'(Y_LIMIT - 1);
  localparam logic [WALK_W-1:0]    WALK_END    = WALK_W'(CELLS);
  localparam logic [RETRY_W-1:0]   RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);
  localparam logic [X_W-1:0]       BOX_X_RST   = X_W'(32);
  localparam logic [Y_W-1:0]       BOX_Y_RST   = Y_W'(8);

  typedef enum logic [2:0] {StIdle, StLatch, StScan, StWalk, StCommit, StFull} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [LEN_W-1:0]   seg_addr_q, seg_addr_d;
  logic [X_W-1:0]     cand_x_q, cand_x_d, box_x_q, box_x_d;
  logic [Y_W-1:0]     cand_y_q, cand_y_d, box_y_q, box_y_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               walk_q, walk_d;
  logic [WALK_W-1:0]  walk_cnt_q, walk_cnt_d;
  logic               pending_q, pending_d;

  logic [X_W-1:0]     lat_x, wx, wx_n;
  logic [Y_W-1:0]     lat_y, wy, wy_n;
  logic               reject, start_req, box_load, busy;

  assign busy = (state_q != StIdle) && (state_q != StFull);

  // Next walk cell: clamp the last candidate into the board, then raster-step with wrap.
  always_comb begin
    wx   = ({1'b0, cand_x_q} < X_LIM) ? cand_x_q : '0;
    wy   = ({1'b0, cand_y_q} < Y_LIM) ? cand_y_q : '0;
    wx_n = wx + 1'b1;
    wy_n = wy;
    if (wx == X_LAST) begin
      wx_n = '0;
      wy_n = (wy == Y_LAST) ? '0 : wy + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    scan_cnt_d = scan_cnt_q;
    seg_addr_d = seg_addr_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    box_x_d    = box_x_q;
    box_y_d    = box_y_q;
    retry_d    = retry_q;
    walk_d     = walk_q;
    walk_cnt_d = walk_cnt_q;
    pending_d  = pending_q;
    reject     = 1'b0;
    start_req  = 1'b0;
    box_load   = 1'b0;
    lat_x      = walk_q ? cand_x_q : bus.rand_num_x;
    lat_y      = walk_q ? cand_y_q : bus.rand_num_y;

    case (state_q)
      StIdle: begin
        if (bus.eat) begin
          state_d   = StLatch;
          start_req = 1'b1;
        end
      end
      StLatch: begin
        cand_x_d = lat_x;
        cand_y_d = lat_y;
        if (({1'b0, lat_x} >= X_LIM) || ({1'b0, lat_y} >= Y_LIM)) begin
          reject = 1'b1;
        end else if (len_q == '0) begin
          // Box coordinates are loaded on entry so they are valid alongside box_load.
          state_d = StCommit;
          box_x_d = lat_x;
          box_y_d = lat_y;
        end else begin
          state_d    = StScan;
          scan_cnt_d = '0;
          seg_addr_d = '0;
        end
      end
      StScan: begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        if (seg_addr_q != len_q - 1'b1) seg_addr_d = seg_addr_q + 1'b1;
        // Read data trails the address by one cycle, so compare slot 0 carries no data.
        if ((scan_cnt_q != '0) && (bus.seg_x == cand_x_q) && (bus.seg_y == cand_y_q)) begin
          reject = 1'b1;
        end else if (scan_cnt_q == len_q) begin
          state_d = StCommit;
          box_x_d = cand_x_q;
          box_y_d = cand_y_q;
        end
      end
      StWalk: begin
        if (walk_cnt_q == WALK_END) begin
          state_d = StFull;
        end else begin
          cand_x_d   = wx_n;
          cand_y_d   = wy_n;
          walk_cnt_d = walk_cnt_q + 1'b1;
          state_d    = StLatch;
        end
      end
      StCommit: begin
        box_load = 1'b1;
        if (pending_q || bus.eat) begin
          state_d   = StLatch;
          start_req = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StFull: ;
      default: state_d = StIdle;
    endcase

    if (reject) begin
      if (!walk_q && (retry_q < RETRY_LAST)) begin
        retry_d = retry_q + 1'b1;
        state_d = StLatch;
      end else begin
        walk_d  = 1'b1;
        state_d = StWalk;
      end
    end

    if (bus.eat && busy && (state_q != StCommit)) pending_d = 1'b1;

    // New game aborts whatever is in flight, including a commit about to be entered.
    if (bus.game_start) begin
      state_d   = StLatch;
      start_req = 1'b1;
      box_x_d   = box_x_q;
      box_y_d   = box_y_q;
    end

    if (start_req) begin
      len_d      = bus.snake_len;
      retry_d    = '0;
      walk_d     = 1'b0;
      walk_cnt_d = '0;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      scan_cnt_q <= '0;
      seg_addr_q <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      box_x_q    <= BOX_X_RST;
      box_y_q    <= BOX_Y_RST;
      retry_q    <= '0;
      walk_q     <= 1'b0;
      walk_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      scan_cnt_q <= scan_cnt_d;
      seg_addr_q <= seg_addr_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
      retry_q    <= retry_d;
      walk_q     <= walk_d;
      walk_cnt_q <= walk_cnt_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.seg_addr   = seg_addr_q;
  assign bus.box_x      = box_x_q;
  assign bus.box_y      = box_y_q;
  assign bus.box_load   = box_load;
  assign bus.busy       = busy;
  assign bus.board_full = (state_q == StFull);

endmodule

// File: tb/tb_box_place_ctrl.sv
// Scoreboard bench for box_place_ctrl: directed cases plus randomized requests checked against
// an attempt-level placement model; a second small-board instance exercises the full-board path.
module tb_box_place_ctrl;
  localparam int XW = 7, YW = 5, LW = 6, XL = 64, YL = 32, MR = 8, NCYC = 40000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;
  int   rx[NCYC], ry[NCYC];
  int   bx[64], by[64], sbx[64], sby[64];

  typedef struct {int lc; int x; int y;} exp_t;
  exp_t sb[$];

  box_place_ctrl_if #(.X_W(XW), .Y_W(YW), .LEN_W(LW)) bus ();
  box_place_ctrl_if #(.X_W(XW), .Y_W(YW), .LEN_W(LW)) sbus ();

  box_place_ctrl #(.X_W(XW), .Y_W(YW), .X_LIMIT(XL), .Y_LIMIT(YL), .LEN_W(LW), .MAX_RETRY(MR))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  box_place_ctrl #(.X_W(XW), .Y_W(YW), .X_LIMIT(4), .Y_LIMIT(2), .LEN_W(LW), .MAX_RETRY(MR))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read body memories.
  always @(posedge clk) begin
    bus.seg_x  <= XW'(bx[bus.seg_addr]);
    bus.seg_y  <= YW'(by[bus.seg_addr]);
    sbus.seg_x <= XW'(sbx[sbus.seg_addr]);
    sbus.seg_y <= YW'(sby[sbus.seg_addr]);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (cyc < NCYC) begin
      bus.rand_num_x  = XW'(rx[cyc]);
      bus.rand_num_y  = YW'(ry[cyc]);
      sbus.rand_num_x = XW'(rx[cyc]);
      sbus.rand_num_y = YW'(ry[cyc]);
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus.box_load === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_load: cycle %0d box=(%0d,%0d), none required", cyc,
                 bus.box_x, bus.box_y);
      end else begin
        e = sb.pop_front();
        if (cyc != e.lc || int'(bus.box_x) != e.x || int'(bus.box_y) != e.y) begin
          miscompares++;
          $display("FAIL box_load: got cycle %0d (%0d,%0d), required cycle %0d (%0d,%0d)",
                   cyc, bus.box_x, bus.box_y, e.lc, e.x, e.y);
        end
      end
    end
    if (rst_n && sbus.box_load === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL small_load: cycle %0d got box_load=1, required 0", cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Attempt-level model: each attempt starts with a LATCH cycle t and ends in commit or reject.
  function automatic void place(input int n, input int len, output int lc, output int ex,
                                output int ey, output bit full);
    int t = n + 1, r = 0, retry = 0, wc = 0, hit, cx = 0, cy = 0;
    bit walking = 1'b0;
    full = 1'b0;
    lc = -1; ex = 0; ey = 0;
    for (int guard = 0; guard < 100000; guard++) begin
      if (!walking) begin
        cx = rx[t];
        cy = ry[t];
      end
      if (cx >= XL || cy >= YL) begin
        r = t;
      end else if (len == 0) begin
        lc = t + 1; ex = cx; ey = cy;
        return;
      end else begin
        hit = -1;
        for (int i = 0; i < len; i++) if (hit < 0 && bx[i] == cx && by[i] == cy) hit = i;
        if (hit < 0) begin
          lc = t + len + 2; ex = cx; ey = cy;
          return;
        end
        r = t + hit + 2;
      end
      retry++;
      if (!walking && retry < MR) begin
        t = r + 1;
      end else begin
        walking = 1'b1;
        if (wc == XL * YL) begin
          full = 1'b1; lc = r + 1;
          return;
        end
        if (cx >= XL) cx = 0;
        if (cy >= YL) cy = 0;
        cx = cx + 1;
        if (cx == XL) begin
          cx = 0;
          cy = (cy + 1) % YL;
        end
        wc++;
        t = r + 2;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    int g = 0;
    while (cyc < c && g < 20000) begin
      tick();
      g++;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_req(input int n, input int len, output int lc);
    int ex, ey;
    bit full;
    place(n, len, lc, ex, ey, full);
    if (!full) sb.push_back('{lc, ex, ey});
  endtask

  task automatic set_rand(input int from, input int to, input int x, input int y);
    for (int t = from; t <= to; t++) begin
      rx[t] = x;
      ry[t] = y;
    end
  endtask

  task automatic set_body3();
    bx[0] = 1; by[0] = 1;
    bx[1] = 2; by[1] = 1;
    bx[2] = 3; by[2] = 1;
    bus.snake_len = 6'd3;
  endtask

  initial begin
    int n, lc1, lc2, len, g;
    for (int t = 0; t < NCYC; t++) begin
      case ($urandom % 4)
        0:       rx[t] = $urandom_range(127, 64);
        1, 2:    rx[t] = $urandom_range(7, 0);
        default: rx[t] = $urandom_range(63, 0);
      endcase
      ry[t] = ($urandom % 2 == 1) ? $urandom_range(3, 0) : $urandom_range(31, 0);
    end
    for (int i = 0; i < 64; i++) begin
      bx[i] = 127; by[i] = 31;
      sbx[i] = i % 4; sby[i] = (i / 4) % 2;
    end
    bus.eat = 1'b0;  bus.game_start = 1'b0;  bus.snake_len = '0;
    sbus.eat = 1'b0; sbus.game_start = 1'b0; sbus.snake_len = '0;

    repeat (3) tick();
    check("rst_box_x", int'(bus.box_x), 32);
    check("rst_box_y", int'(bus.box_y), 8);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_board_full", int'(bus.board_full), 0);
    check("rst_seg_addr", int'(bus.seg_addr), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Empty snake: commit two cycles after the request.
    n = cyc; set_rand(n + 1, n + 1, 10, 5); bus.snake_len = '0;
    bus.eat = 1'b1; sb.push_back('{n + 2, 10, 5});
    tick(); bus.eat = 1'b0;
    wait_until(n + 5);
    check("t1_idle", int'(bus.busy), 0);

    // Three-segment body, free cell: address sequence 0,1,2 then commit.
    set_body3(); n = cyc; set_rand(n + 1, n + 1, 20, 7);
    bus.eat = 1'b1; sb.push_back('{n + 6, 20, 7});
    tick(); bus.eat = 1'b0;
    tick(); check("t2_addr0", int'(bus.seg_addr), 0);
    tick(); check("t2_addr1", int'(bus.seg_addr), 1);
    tick(); check("t2_addr2", int'(bus.seg_addr), 2);
    wait_until(n + 9);
    check("t2_idle", int'(bus.busy), 0);

    // First sample hits segment 1, second sample is free.
    n = cyc; set_rand(n + 1, n + 1, 2, 1); set_rand(n + 2, n + 20, 40, 9);
    bus.eat = 1'b1; sb.push_back('{n + 10, 40, 9});
    tick(); bus.eat = 1'b0;
    wait_until(n + 13);

    // Random source stuck on the head: eight rejects, then walk to (4,1).
    n = cyc; set_rand(n + 1, n + 60, 1, 1);
    bus.eat = 1'b1; sb.push_back('{n + 42, 4, 1});
    tick(); bus.eat = 1'b0;
    wait_until(n + 45);
    check("t4_idle", int'(bus.busy), 0);

    // Eat mid-scan queues one more placement; a further eat while pending is dropped.
    n = cyc; set_rand(n + 1, n + 30, 20, 7);
    bus.eat = 1'b1; sb.push_back('{n + 6, 20, 7}); sb.push_back('{n + 12, 20, 7});
    tick(); bus.eat = 1'b0;
    tick(); tick(); bus.eat = 1'b1;
    tick(); tick(); bus.eat = 1'b0;
    wait_until(n + 16);
    check("t5_idle", int'(bus.busy), 0);

    // New game mid-scan restarts the placement; only the restarted one commits.
    n = cyc; set_rand(n + 1, n + 30, 20, 7);
    bus.eat = 1'b1;
    tick(); bus.eat = 1'b0;
    tick(); tick(); bus.game_start = 1'b1; sb.push_back('{n + 9, 20, 7});
    tick(); bus.game_start = 1'b0;
    wait_until(n + 12);

    // Reset mid-scan: outputs return to reset values and nothing commits.
    n = cyc; set_rand(n + 1, n + 30, 33, 3);
    bus.eat = 1'b1;
    tick(); bus.eat = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_box_x", int'(bus.box_x), 32);
    check("mid_rst_box_y", int'(bus.box_y), 8);
    check("mid_rst_box_load", int'(bus.box_load), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_seg_addr", int'(bus.seg_addr), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) tick();
    check("post_rst_busy", int'(bus.busy), 0);

    // Small board fully covered by the body: ends in FULL, game_start leaves it.
    sbus.snake_len = 6'd8; sbus.eat = 1'b1;
    tick(); sbus.eat = 1'b0;
    g = 0;
    while (sbus.board_full !== 1'b1 && g < 5000) begin
      tick();
      g++;
    end
    check("small_board_full", int'(sbus.board_full), 1);
    check("small_full_busy", int'(sbus.busy), 0);
    repeat (5) tick();
    check("small_full_held", int'(sbus.board_full), 1);
    sbus.game_start = 1'b1;
    tick(); sbus.game_start = 1'b0;
    check("small_cleared", int'(sbus.board_full), 0);
    check("small_restart_busy", int'(sbus.busy), 1);

    // Randomized requests, some with a second eat while the first is in flight.
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(12, 0);
      for (int i = 0; i < 64; i++) begin
        bx[i] = (i < len) ? $urandom_range(7, 0) : 127;
        by[i] = (i < len) ? $urandom_range(3, 0) : 31;
      end
      bus.snake_len = LW'(len);
      n = cyc;
      bus.eat = 1'b1;
      model_req(n, len, lc1);
      lc2 = lc1;
      tick(); bus.eat = 1'b0;
      tick();
      if ($urandom % 3 == 0) begin
        bus.eat = 1'b1;
        model_req(lc1, len, lc2);
      end
      tick(); bus.eat = 1'b0;
      wait_until(lc2 + 3);
      check("rand_idle", int'(bus.busy), 0);
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
